sram_bus_arbiter: RTL and testbench

- 2:1 arbiter that shares one sram-like memory port between the instruction-fetch master (preIF/IF) and the data master (EX/MEM).
- Grants address handshakes and records the owner of each accepted request in an in-order tag FIFO. Returns each data_ok/rdata to the owning master.
- Sits between the CPU core and the memory bridge.

---
 rtl/sram_bus_arbiter_pkg.sv | 19 +
 rtl/sram_bus_arbiter_tag_fifo.sv | 53 +++++
 rtl/sram_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the inst/data SRAM bus arbiter.
package sram_bus_arbiter_pkg;

  // Owner tag stored per accepted request. The bit value is the encoding.
  typedef enum logic {
    TAG_INST = 1'b0,
    TAG_DATA = 1'b1
  } owner_e;

  // Request lock: the owner whose request is visible downstream but not yet accepted.
  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_e;

  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/sram_bus_arbiter_tag_fifo.sv
// In-order owner-tag FIFO: one tag per accepted request, popped per response.
module arb_tag_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push_i,
  input  owner_e din_i,
  input  logic   pop_i,
  output logic   full_o,
  output logic   empty_o,
  output owner_e head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [DEPTH-1:0] tag_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when a pop frees the head slot.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = owner_e'(tag_q[rd_ptr_q]);

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        tag_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// 2:1 arbiter sharing one sram-like port between the inst and data masters.
// Accepted requests are tagged in order; responses are routed by the head tag.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int OUTST_DEPTH = 4,
  parameter int STARVE_LIM  = 4,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          resetn,
  // inst master
  input  logic          inst_sram_req,
  input  logic          inst_sram_wr,
  input  logic [1:0]    inst_sram_size,
  input  logic [3:0]    inst_sram_wstrb,
  input  logic [AW-1:0] inst_sram_addr,
  input  logic [DW-1:0] inst_sram_wdata,
  output logic          inst_sram_addr_ok,
  output logic          inst_sram_data_ok,
  output logic [DW-1:0] inst_sram_rdata,
  // data master
  input  logic          data_sram_req,
  input  logic          data_sram_wr,
  input  logic [1:0]    data_sram_size,
  input  logic [3:0]    data_sram_wstrb,
  input  logic [AW-1:0] data_sram_addr,
  input  logic [DW-1:0] data_sram_wdata,
  output logic          data_sram_addr_ok,
  output logic          data_sram_data_ok,
  output logic [DW-1:0] data_sram_rdata,
  // downstream port
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_err
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = STARVE_LIM[SW-1:0];

  lock_e         lock_q, lock_d;
  owner_e        grant, head;
  logic [SW-1:0] starve_q, starve_d;
  logic          arb_err_q, arb_err_d;
  logic          grant_req, accept, pop;
  logic          fifo_full, fifo_empty;

  // Grant select: a lock pins the owner, else starvation override, else data first.
  always_comb begin
    grant = TAG_INST;
    unique case (lock_q)
      LK_INST: grant = TAG_INST;
      LK_DATA: grant = TAG_DATA;
      default: begin
        if (starve_q == STARVE_MAX && inst_sram_req) grant = TAG_INST;
        else if (data_sram_req)                      grant = TAG_DATA;
        else                                         grant = TAG_INST;
      end
    endcase
  end

  assign grant_req = (grant == TAG_DATA) ? data_sram_req : inst_sram_req;
  // No full-bypass: the request path never depends on mem_data_ok.
  assign mem_req   = resetn && grant_req && !fifo_full;
  assign accept    = mem_req && mem_addr_ok;

  assign mem_wr    = (grant == TAG_DATA) ? data_sram_wr    : inst_sram_wr;
  assign mem_size  = (grant == TAG_DATA) ? data_sram_size  : inst_sram_size;
  assign mem_wstrb = (grant == TAG_DATA) ? data_sram_wstrb : inst_sram_wstrb;
  assign mem_addr  = (grant == TAG_DATA) ? data_sram_addr  : inst_sram_addr;
  assign mem_wdata = (grant == TAG_DATA) ? data_sram_wdata : inst_sram_wdata;

  assign inst_sram_addr_ok = accept && (grant == TAG_INST);
  assign data_sram_addr_ok = accept && (grant == TAG_DATA);

  // Responses: head tag steers data_ok, rdata goes to both masters.
  assign pop               = resetn && mem_data_ok && !fifo_empty;
  assign inst_sram_data_ok = pop && (head == TAG_INST);
  assign data_sram_data_ok = pop && (head == TAG_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;
  assign arb_err           = arb_err_q;

  arb_tag_fifo #(.DEPTH(OUTST_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (accept),
    .din_i   (grant),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // Lock next state: hold a stalled downstream request on its owner until accepted.
  always_comb begin
    lock_d = lock_q;
    if (mem_req && !mem_addr_ok) lock_d = (grant == TAG_DATA) ? LK_DATA : LK_INST;
    else if (accept)             lock_d = LK_NONE;
  end

  // Starvation count of data accepts while inst waits; saturating.
  always_comb begin
    starve_d = starve_q;
    if (!inst_sram_req || (accept && grant == TAG_INST))
      starve_d = '0;
    else if (accept && grant == TAG_DATA && starve_q != STARVE_MAX)
      starve_d = starve_q + 1'b1;
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_comb begin
    arb_err_d = arb_err_q | (mem_data_ok && fifo_empty);
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q    <= LK_NONE;
      starve_q  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      lock_q    <= lock_d;
      starve_q  <= starve_d;
      arb_err_q <= arb_err_d;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench with a response scoreboard for sram_bus_arbiter.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, arb_err;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        own;   // 0 = inst, 1 = data
    logic [31:0] rd;
  } exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  sram_bus_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Memory answers this cycle; the owner the bench expects is queued.
  task automatic resp(input logic own, input logic [31:0] rd);
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    exp_q.push_back('{own: own, rd: rd});
  endtask

  // Monitor: every data_ok pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (resetn && (inst_sram_data_ok || data_sram_data_ok)) begin
      exp_t e;
      checks++;
      if (inst_sram_data_ok && data_sram_data_ok) begin
        failures++;
        $display("FAIL resp_both: inst and data data_ok both high, required one");
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected: data_ok inst=%0b data=%0b, required none",
                 inst_sram_data_ok, data_sram_data_ok);
      end else begin
        e = exp_q.pop_front();
        if (data_sram_data_ok !== e.own || inst_sram_rdata !== e.rd || data_sram_rdata !== e.rd) begin
          failures++;
          $display("FAIL resp_route: owner=%0b rdata=%0h/%0h, required owner=%0b rdata=%0h",
                   data_sram_data_ok, inst_sram_rdata, data_sram_rdata, e.own, e.rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat [10];
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    resetn = 1'b0;
    inst_sram_wr = 1'b0; inst_sram_size = SRAM_SIZE_WORD; inst_sram_wstrb = 4'hF;
    inst_sram_wdata = 32'h0; inst_sram_addr = 32'h1C000000;
    data_sram_wr = 1'b0; data_sram_size = SRAM_SIZE_WORD; data_sram_wstrb = 4'hF;
    data_sram_wdata = 32'h0; data_sram_addr = 32'h1C000100;
    mem_rdata = 32'h0;
    // Drive everything active during reset: outputs must still be forced low.
    inst_sram_req = 1'b1; data_sram_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    #3;
    chk("rst_mem_req",   mem_req, 0);
    chk("rst_inst_aok",  inst_sram_addr_ok, 0);
    chk("rst_data_aok",  data_sram_addr_ok, 0);
    chk("rst_inst_dok",  inst_sram_data_ok, 0);
    chk("rst_data_dok",  data_sram_data_ok, 0);
    chk("rst_arb_err",   arb_err, 0);
    inst_sram_req = 1'b0; data_sram_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;

    // 1: simultaneous reads, data wins then inst; responses routed data, inst.
    inst_sram_req = 1'b1; data_sram_req = 1'b1; mem_addr_ok = 1'b1;
    smp();
    chk("t1_addr0", mem_addr, 32'h1C000100);
    chk("t1_data_aok", data_sram_addr_ok, 1);
    chk("t1_inst_aok0", inst_sram_addr_ok, 0);
    cyc(); data_sram_req = 1'b0;
    smp();
    chk("t1_addr1", mem_addr, 32'h1C000000);
    chk("t1_inst_aok", inst_sram_addr_ok, 1);
    cyc(); inst_sram_req = 1'b0; mem_addr_ok = 1'b0;
    resp(1'b1, 32'h11); smp(); cyc();
    resp(1'b0, 32'h22); smp(); cyc();
    mem_data_ok = 1'b0;

    // 2: stalled inst request stays locked while data rises.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000004; data_sram_addr = 32'h1C000200;
    smp();
    chk("t2_c1_req", mem_req, 1);
    chk("t2_c1_addr", mem_addr, 32'h1C000004);
    chk("t2_c1_inst_aok", inst_sram_addr_ok, 0);
    cyc(); data_sram_req = 1'b1;
    smp();
    chk("t2_c2_addr", mem_addr, 32'h1C000004);
    chk("t2_c2_data_aok", data_sram_addr_ok, 0);
    cyc(); smp();
    chk("t2_c3_addr", mem_addr, 32'h1C000004);
    cyc(); mem_addr_ok = 1'b1;
    smp();
    chk("t2_c4_inst_aok", inst_sram_addr_ok, 1);
    chk("t2_c4_data_aok", data_sram_addr_ok, 0);
    cyc(); inst_sram_req = 1'b0;
    smp();
    chk("t2_c5_data_aok", data_sram_addr_ok, 1);
    chk("t2_c5_addr", mem_addr, 32'h1C000200);
    cyc(); data_sram_req = 1'b0; mem_addr_ok = 1'b0;
    resp(1'b0, 32'h33); smp(); cyc();
    resp(1'b1, 32'h44); smp(); cyc();
    mem_data_ok = 1'b0;

    // 3: fill the tag FIFO, no bypass on a same-cycle pop, reassert after.
    data_sram_req = 1'b1; mem_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_sram_addr = 32'h1C001000 + 32'(4 * i);
      smp();
      chk("t3_fill_aok", data_sram_addr_ok, 1);
      cyc();
    end
    smp();
    chk("t3_full_req", mem_req, 0);
    chk("t3_full_aok", data_sram_addr_ok, 0);
    cyc(); resp(1'b1, 32'h55);
    smp();
    chk("t3_pop_no_bypass", mem_req, 0);
    cyc(); mem_data_ok = 1'b0;
    smp();
    chk("t3_reassert_req", mem_req, 1);
    chk("t3_reassert_aok", data_sram_addr_ok, 1);
    cyc(); data_sram_req = 1'b0; mem_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp(1'b1, 32'h56 + 32'(i)); smp(); cyc();
    end
    mem_data_ok = 1'b0;

    // 4: starvation: four data grants then one forced inst, repeating.
    inst_sram_req = 1'b1; data_sram_req = 1'b1; mem_addr_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) resp(pat[k-1][0], 32'h60 + 32'(k));
      else       mem_data_ok = 1'b0;
      smp();
      chk("t4_data_aok", data_sram_addr_ok, pat[k][0]);
      chk("t4_inst_aok", inst_sram_addr_ok, !pat[k][0]);
      cyc();
    end
    inst_sram_req = 1'b0; data_sram_req = 1'b0; mem_addr_ok = 1'b0;
    resp(pat[9][0], 32'h6A); smp(); cyc();
    mem_data_ok = 1'b0;

    // 5a: response with nothing outstanding.
    mem_data_ok = 1'b1; mem_rdata = 32'h99;
    smp();
    chk("t5_empty_inst_dok", inst_sram_data_ok, 0);
    chk("t5_empty_data_dok", data_sram_data_ok, 0);
    chk("t5_err_before_edge", arb_err, 0);
    cyc(); mem_data_ok = 1'b0;
    smp(); chk("t5_err_set", arb_err, 1);
    cyc(); smp(); chk("t5_err_sticky", arb_err, 1);
    cyc();

    // 5b: two accepts plus a stalled (locked) data request, then async reset.
    data_sram_req = 1'b1; mem_addr_ok = 1'b1; data_sram_addr = 32'h1C002000;
    smp(); cyc(); smp(); cyc();
    mem_addr_ok = 1'b0;
    smp(); chk("t5_stall_req", mem_req, 1);
    cyc();
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_err", arb_err, 0);
    chk("t5_async_req", mem_req, 0);
    chk("t5_async_aok", data_sram_addr_ok, 0);
    data_sram_req = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    // A surviving data lock would hide this inst request.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000008;
    smp();
    chk("t5_nolock_req", mem_req, 1);
    chk("t5_nolock_addr", mem_addr, 32'h1C000008);
    chk("t5_err_cleared", arb_err, 0);
    cyc(); mem_addr_ok = 1'b1;
    smp(); chk("t5_inst_aok", inst_sram_addr_ok, 1);
    cyc(); inst_sram_req = 1'b0; mem_addr_ok = 1'b0;
    // Stale pre-reset tags would misroute this or answer the next pulse.
    resp(1'b0, 32'h77); smp(); cyc();
    mem_data_ok = 1'b1; mem_rdata = 32'h78;
    smp();
    chk("t5_fifo_empty_inst", inst_sram_data_ok, 0);
    chk("t5_fifo_empty_data", data_sram_data_ok, 0);
    cyc(); mem_data_ok = 1'b0;
    smp(); chk("t5_err_again", arb_err, 1);
    cyc();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
